lsram_fifo_ctrl: RTL and testbench

- Sequences one simple dual-port LSRAM (registered read, 1-cycle read latency, no reset) as a synchronous first-word-fall-through (FWFT) FIFO.
- Used for the per-channel read/write data buffers of the DDR AXI4 arbiter.
- Owns the write and read pointers, occupancy, flags, and a 2-entry output stage that hides the RAM read latency.
- Sustains one push and one pop per clock.

---
 rtl/lsram_fifo_pkg.sv | 14 +
 rtl/lsram_fifo_ctrl_if.sv | 42 ++++
 rtl/lsram_fifo_outstage.sv | 73 +++++++
 rtl/lsram_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_lsram_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsram_fifo_pkg.sv
// rtl/lsram_fifo_pkg.sv - shared defaults and width helper for the LSRAM FIFO controller
package lsram_fifo_pkg;

    localparam int DWIDTH_DEF     = 32;
    localparam int AWIDTH_DEF     = 7;
    localparam int AFULL_LVL_DEF  = 120;
    localparam int AEMPTY_LVL_DEF = 4;

    // COUNT must be able to hold the full depth, hence one bit wider than the address
    function automatic int count_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/lsram_fifo_ctrl_if.sv
// rtl/lsram_fifo_ctrl_if.sv - user push/pop port and LSRAM port bundle of the FIFO controller
interface lsram_fifo_ctrl_if
    import lsram_fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
);
    localparam int CWIDTH = count_width(AWIDTH);

    logic              WR_EN;
    logic [DWIDTH-1:0] WR_DATA;
    logic              RD_EN;
    logic [DWIDTH-1:0] DOUT;
    logic              DOUT_VALID;
    logic              FULL;
    logic              ALMOST_FULL;
    logic              ALMOST_EMPTY;
    logic [CWIDTH-1:0] COUNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic              RAM_W_EN;
    logic [AWIDTH-1:0] RAM_W_ADDR;
    logic [DWIDTH-1:0] RAM_W_DATA;
    logic              RAM_R_EN;
    logic [AWIDTH-1:0] RAM_R_ADDR;
    logic [DWIDTH-1:0] RAM_R_DATA;

    modport slave (
        input  WR_EN, WR_DATA, RD_EN, RAM_R_DATA,
        output DOUT, DOUT_VALID, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT,
               OVERFLOW, UNDERFLOW, RAM_W_EN, RAM_W_ADDR, RAM_W_DATA,
               RAM_R_EN, RAM_R_ADDR
    );

    modport master (
        output WR_EN, WR_DATA, RD_EN, RAM_R_DATA,
        input  DOUT, DOUT_VALID, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT,
               OVERFLOW, UNDERFLOW, RAM_W_EN, RAM_W_ADDR, RAM_W_DATA,
               RAM_R_EN, RAM_R_ADDR
    );

endinterface

// File: rtl/lsram_fifo_outstage.sv
// rtl/lsram_fifo_outstage.sv - head/skid output registers that hide the 1-cycle LSRAM read latency
module lsram_fifo_outstage
    import lsram_fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] ram_r_data,
    input  logic              pop,
    input  logic              issue,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    output logic [1:0]        out_occ,
    output logic              inflight
);

    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] skid_q, skid_d;
    logic              head_vld_q, head_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic              inflight_q, inflight_d;

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        inflight_d = issue;

        if (pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                head_vld_d = 1'b0;
            end
        end

        // Read data lands in the head if the pop above emptied it, otherwise it queues behind
        if (inflight_q) begin
            if (!head_vld_d) begin
                head_d     = ram_r_data;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = ram_r_data;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            inflight_q <= inflight_d;
        end
    end

    assign dout       = head_q;
    assign dout_valid = head_vld_q;
    assign out_occ    = {1'b0, head_vld_q} + {1'b0, skid_vld_q};
    assign inflight   = inflight_q;

endmodule

// File: rtl/lsram_fifo_ctrl.sv
// rtl/lsram_fifo_ctrl.sv - FWFT FIFO sequencer for one simple dual-port LSRAM placed beside it
module lsram_fifo_ctrl
    import lsram_fifo_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int AFULL_LVL  = AFULL_LVL_DEF,
    parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
    input  logic             CLK,
    input  logic             RESETN,
    lsram_fifo_ctrl_if.slave bus
);

    localparam int                CWIDTH     = count_width(AWIDTH);
    localparam logic [CWIDTH-1:0] DEPTH      = CWIDTH'(2 ** AWIDTH);
    localparam logic [CWIDTH-1:0] AFULL_CNT  = CWIDTH'(AFULL_LVL);
    localparam logic [CWIDTH-1:0] AEMPTY_CNT = CWIDTH'(AEMPTY_LVL);

    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic [CWIDTH-1:0] ram_cnt_q, ram_cnt_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              push_acc;
    logic              pop_acc;
    logic              issue;
    logic [2:0]        occ_after_pop;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic [1:0]        out_occ;
    logic              inflight;

    always_comb begin
        // FULL is the registered value, so a same-cycle pop never makes room for a push
        push_acc      = bus.WR_EN & ~full_q;
        pop_acc       = bus.RD_EN & dout_valid;
        occ_after_pop = {1'b0, out_occ} + {2'b0, inflight} - {2'b0, pop_acc};
        issue         = (ram_cnt_q != '0) && (occ_after_pop < 3'd2);

        wptr_d    = wptr_q + AWIDTH'(push_acc);
        rptr_d    = rptr_q + AWIDTH'(issue);
        ram_cnt_d = ram_cnt_q + CWIDTH'(push_acc) - CWIDTH'(issue);
        count_d   = count_q + CWIDTH'(push_acc) - CWIDTH'(pop_acc);

        full_d   = (count_d == DEPTH);
        afull_d  = (count_d >= AFULL_CNT);
        aempty_d = (count_d <= AEMPTY_CNT);
        ovf_d    = bus.WR_EN & full_q;
        udf_d    = bus.RD_EN & ~dout_valid;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ram_cnt_q <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ram_cnt_q <= ram_cnt_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    lsram_fifo_outstage #(
        .DWIDTH (DWIDTH)
    ) u_outstage (
        .clk        (CLK),
        .rst_n      (RESETN),
        .ram_r_data (bus.RAM_R_DATA),
        .pop        (pop_acc),
        .issue      (issue),
        .dout       (dout),
        .dout_valid (dout_valid),
        .out_occ    (out_occ),
        .inflight   (inflight)
    );

    assign bus.RAM_W_EN     = push_acc;
    assign bus.RAM_W_ADDR   = wptr_q;
    assign bus.RAM_W_DATA   = bus.WR_DATA;
    assign bus.RAM_R_EN     = issue;
    assign bus.RAM_R_ADDR   = rptr_q;
    assign bus.DOUT         = dout;
    assign bus.DOUT_VALID   = dout_valid;
    assign bus.COUNT        = count_q;
    assign bus.FULL         = full_q;
    assign bus.ALMOST_FULL  = afull_q;
    assign bus.ALMOST_EMPTY = aempty_q;
    assign bus.OVERFLOW     = ovf_q;
    assign bus.UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_lsram_fifo_ctrl.sv
// tb/tb_lsram_fifo_ctrl.sv - self-checking bench for lsram_fifo_ctrl with a behavioural LSRAM and queue model
module tb_lsram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   edge_n;
    int   wcount;
    logic last_ren;

    logic [DW-1:0] mq[$];
    int            mt[$];

    lsram_fifo_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    lsram_fifo_ctrl #(
        .DWIDTH     (DW),
        .AWIDTH     (AW),
        .AFULL_LVL  (120),
        .AEMPTY_LVL (4)
    ) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus.slave)
    );

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_rdata;

    always @(posedge clk) begin
        if (bus.RAM_W_EN) mem[bus.RAM_W_ADDR] <= bus.RAM_W_DATA;
        if (bus.RAM_R_EN) ram_rdata <= mem[bus.RAM_R_ADDR];
    end
    assign bus.RAM_R_DATA = ram_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        bit        wr;
        logic [31:0] d;
        bit        rd;
        bit        ren;
        int        cnt;
        bit        vld;
        logic [31:0] dout;
        bit        ae;
        bit        udf;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_valid();
        return (mq.size() != 0) && (mt[0] + 2 <= edge_n);
    endfunction

    task automatic check_state(input bit exp_ovf, input bit exp_udf);
        int n;
        bit v;
        n = mq.size();
        v = model_valid();
        chk("count", bus.COUNT, n);
        chk("full", bus.FULL, n == DEPTH);
        chk("almost_full", bus.ALMOST_FULL, n >= 120);
        chk("almost_empty", bus.ALMOST_EMPTY, n <= 4);
        chk("dout_valid", bus.DOUT_VALID, v);
        if (v) chk("dout", bus.DOUT, mq[0]);
        chk("overflow", bus.OVERFLOW, exp_ovf);
        chk("underflow", bus.UNDERFLOW, exp_udf);
    endtask

    task automatic step(input bit wr, input logic [31:0] d, input bit rd);
        bit full_m, vld_m, push_m, pop_m;
        full_m = (mq.size() == DEPTH);
        vld_m  = model_valid();
        push_m = wr && !full_m;
        pop_m  = rd && vld_m;
        bus.WR_EN   = wr;
        bus.WR_DATA = d;
        bus.RD_EN   = rd;
        #1;
        last_ren = bus.RAM_R_EN;
        chk("ram_w_en", bus.RAM_W_EN, push_m);
        if (push_m) begin
            chk("ram_w_addr", bus.RAM_W_ADDR, wcount % DEPTH);
            chk("ram_w_data", bus.RAM_W_DATA, d);
        end
        @(posedge clk);
        #1;
        if (pop_m) begin
            void'(mq.pop_front());
            void'(mt.pop_front());
        end
        if (push_m) begin
            mq.push_back(d);
            mt.push_back(edge_n);
            wcount++;
        end
        @(negedge clk);
        check_state(wr && full_m, rd && !vld_m);
    endtask

    task automatic do_reset();
        bus.WR_EN   = 1'b0;
        bus.RD_EN   = 1'b0;
        bus.WR_DATA = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        mt.delete();
        wcount = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, bus.COUNT, 0);
        chk({tag, "_dout_valid"}, bus.DOUT_VALID, 0);
        chk({tag, "_dout"}, bus.DOUT, 0);
        chk({tag, "_full"}, bus.FULL, 0);
        chk({tag, "_afull"}, bus.ALMOST_FULL, 0);
        chk({tag, "_aempty"}, bus.ALMOST_EMPTY, 1);
        chk({tag, "_ovf"}, bus.OVERFLOW, 0);
        chk({tag, "_udf"}, bus.UNDERFLOW, 0);
        chk({tag, "_ram_r_en"}, bus.RAM_R_EN, 0);
        chk({tag, "_ram_w_en"}, bus.RAM_W_EN, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        wcount  = 0;
        rst_n   = 1'b0;
        bus.WR_EN   = 1'b0;
        bus.RD_EN   = 1'b0;
        bus.WR_DATA = '0;

        tbl[0] = '{wr:0, d:32'h0,        rd:1, ren:0, cnt:0, vld:0, dout:32'h0,        ae:1, udf:1};
        tbl[1] = '{wr:0, d:32'h0,        rd:0, ren:0, cnt:0, vld:0, dout:32'h0,        ae:1, udf:0};
        tbl[2] = '{wr:1, d:32'hA5A5A5A5, rd:0, ren:0, cnt:1, vld:0, dout:32'h0,        ae:1, udf:0};
        tbl[3] = '{wr:0, d:32'h0,        rd:0, ren:1, cnt:1, vld:0, dout:32'h0,        ae:1, udf:0};
        tbl[4] = '{wr:0, d:32'h0,        rd:0, ren:0, cnt:1, vld:1, dout:32'hA5A5A5A5, ae:1, udf:0};
        tbl[5] = '{wr:0, d:32'h0,        rd:1, ren:0, cnt:0, vld:0, dout:32'h0,        ae:1, udf:0};
        tbl[6] = '{wr:0, d:32'h0,        rd:1, ren:0, cnt:0, vld:0, dout:32'h0,        ae:1, udf:1};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single push latency, pop and underflow on empty
        for (int i = 0; i < 7; i++) begin
            bus.WR_EN   = tbl[i].wr;
            bus.WR_DATA = tbl[i].d;
            bus.RD_EN   = tbl[i].rd;
            #1;
            chk($sformatf("vec%0d_ram_r_en", i), bus.RAM_R_EN, tbl[i].ren);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_count", i), bus.COUNT, tbl[i].cnt);
            chk($sformatf("vec%0d_dout_valid", i), bus.DOUT_VALID, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("vec%0d_dout", i), bus.DOUT, tbl[i].dout);
            chk($sformatf("vec%0d_aempty", i), bus.ALMOST_EMPTY, tbl[i].ae);
            chk($sformatf("vec%0d_udf", i), bus.UNDERFLOW, tbl[i].udf);
        end

        // Fill to FULL, then one rejected push
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, i, 1'b0);
        chk("full_at_128", bus.FULL, 1);
        step(1'b1, 32'd128, 1'b0);
        chk("ovf_129th", bus.OVERFLOW, 1);
        chk("count_after_ovf", bus.COUNT, DEPTH);

        // Push and pop every cycle from FULL across pointer wrap
        for (int i = 0; i < 300; i++) step(1'b1, 32'd1000 + i, 1'b1);

        // Steady 1/cycle streaming at occupancy 64
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 32'h100 + i, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b1, $urandom, 1'b1);
        chk("steady_count", bus.COUNT, 64);

        // Randomised traffic with varying push/pop bias
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            int pw, pr;
            pw = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int i = 0; i < 250; i++)
                step($urandom_range(99) < pw, $urandom, $urandom_range(99) < pr);
        end

        // Asynchronous reset at COUNT=50 with a RAM read outstanding
        do_reset();
        for (int i = 0; i < 51; i++) step(1'b1, 32'h5000 + i, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("pre_reset_count", bus.COUNT, 50);
        chk("pre_reset_read_issued", last_ren, 1);
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        mt.delete();
        wcount = 0;
        step(1'b1, 32'h1, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0);
        chk("post_reset_dout", bus.DOUT, 32'h1);
        chk("post_reset_valid", bus.DOUT_VALID, 1);
        step(1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
